// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmitter and receiver.
// State PARITY is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP,
        PARITY
    } uart_tx_state_t;

    localparam logic UartIdleLevel       = 1'b1;
    localparam int   UartDefaultDataSize = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..div and pulses tick on the wrap cycle.
// Held at zero while clear is high so a bit period starts cleanly.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic                 wrap;

    assign wrap = (cnt_q == div);
    assign tick = ~clear & wrap;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops the TX FIFO and sends 8N1/8N2 frames LSB first.
// Define UART_TX_PARITY_EN to add the parity_odd port and a parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_SIZE = UartDefaultDataSize,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 txen,
    input  logic                 nstop,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_rd_data,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 fifo_rd_en,
    output logic                 txd,
    output logic                 busy
);

    localparam int BitW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_SIZE - 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 nstop_q, nstop_d;
    logic [BitW-1:0]      bit_q, bit_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif
    logic                 tick;
    logic                 clear;

    // Counter is parked outside the bit-timed states so START begins at zero.
    assign clear = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

    uart_baud_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .div  (div_q),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        div_d   = div_q;
        nstop_d = nstop_q;
        bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (txen && !fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_rd_data;
                div_d   = div;
                nstop_d = nstop;
`ifdef UART_TX_PARITY_EN
                par_d   = ^fifo_rd_data ^ parity_odd;
`endif
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LastBit) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (nstop_q && (bit_q == '0)) begin
                        bit_d = BitW'(1);
                    end else begin
                        bit_d = '0;
                        if (txen && !fifo_empty) begin
                            state_d = POP;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            div_q   <= '0;
            nstop_q <= 1'b0;
            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            nstop_q <= nstop_d;
            bit_q   <= bit_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        txd = UartIdleLevel;
        if (state_q == START) begin
            txd = ~UartIdleLevel;
        end else if (state_q == DATA) begin
            txd = shift_q[0];
        end
`ifdef UART_TX_PARITY_EN
        else if (state_q == PARITY) begin
            txd = par_q;
        end
`endif
    end

    assign fifo_rd_en = (state_q == POP);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed and random frames checked cycle by cycle against a frame model.
// Compile with UART_TX_PARITY_EN to cover the parity bit as well.
module tb_uart_tx;

    logic        clock = 1'b0;
    logic        reset;
    logic        txen;
    logic        nstop;
    logic [15:0] div;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en;
    logic        txd;
    logic        busy;
`ifdef UART_TX_PARITY_EN
    logic        parity_odd;
`endif

    int          errors = 0;
    int          checks = 0;
    int          pops;
    int          exp_frames;
    logic        prev_rd;
    logic [7:0]  fifo_q[$];
    logic [7:0]  stim_q[$];
    logic [2:0]  exp_q[$];

    always #5 clock = ~clock;

    uart_tx dut (
        .clock       (clock),
        .reset       (reset),
        .txen        (txen),
        .nstop       (nstop),
        .div         (div),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
`ifdef UART_TX_PARITY_EN
        .parity_odd  (parity_odd),
`endif
        .fifo_rd_en  (fifo_rd_en),
        .txd         (txd),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: FIFO model pops on the edge that ends a fifo_rd_en cycle.
    task automatic step();
        @(posedge clock);
        #1;
        if (prev_rd) begin
            if (fifo_q.size() > 0) begin
                fifo_rd_data = fifo_q.pop_front();
            end
            pops++;
        end
        fifo_empty = (fifo_q.size() == 0);
        prev_rd    = fifo_rd_en;
    endtask

    // Expected {txd, fifo_rd_en, busy} per sampled cycle, from the frame rules.
    task automatic build(input int div_a, input int div_b, input int chg,
                         input bit ns, input int off, input bit podd);
        int   idx;
        int   d;
        int   l;
        logic lv[$];
        logic [7:0] b;
        idx        = 0;
        exp_frames = 0;
        exp_q.delete();
        for (int k = 0; k < stim_q.size(); k++) begin
            exp_q.push_back(3'b111);
            exp_q.push_back(3'b101);
            l    = idx + 1;
            idx += 2;
            d    = (chg >= 0 && chg <= l) ? div_b : div_a;
            b    = stim_q[k];
            lv.delete();
            lv.push_back(1'b0);
            for (int j = 0; j < 8; j++) lv.push_back(b[j]);
`ifdef UART_TX_PARITY_EN
            lv.push_back(^b ^ podd);
`endif
            lv.push_back(1'b1);
            if (ns) lv.push_back(1'b1);
            foreach (lv[m]) begin
                for (int r = 0; r <= d; r++) begin
                    exp_q.push_back({lv[m], 1'b0, 1'b1});
                    idx++;
                end
            end
            exp_frames++;
            if (off >= 0 && off <= idx - 1) break;
        end
        if (podd) begin end
        for (int r = 0; r < 4; r++) exp_q.push_back(3'b100);
    endtask

    task automatic run(input string tag, input int div_a, input int div_b,
                       input int chg, input bit ns, input int off,
                       input bit podd);
        build(div_a, div_b, chg, ns, off, podd);
        fifo_q     = stim_q;
        fifo_empty = (fifo_q.size() == 0);
        div        = 16'(div_a);
        nstop      = ns;
        txen       = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_odd = podd;
`endif
        pops    = 0;
        prev_rd = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            check($sformatf("%s_c%0d", tag, i), {29'd0, txd, fifo_rd_en, busy},
                  {29'd0, exp_q[i]});
            if (i == chg) div = 16'(div_b);
            if (i == off) txen = 1'b0;
        end
        check({tag, "_pops"}, pops, exp_frames);
        check({tag, "_left"}, fifo_q.size(), stim_q.size() - exp_frames);
        txen = 1'b0;
        fifo_q.delete();
        fifo_empty = 1'b1;
        step();
    endtask

    initial begin
        reset        = 1'b1;
        txen         = 1'b0;
        nstop        = 1'b0;
        div          = 16'd0;
        fifo_empty   = 1'b1;
        fifo_rd_data = 8'h00;
        prev_rd      = 1'b0;
        pops         = 0;
`ifdef UART_TX_PARITY_EN
        parity_odd   = 1'b0;
`endif
        #1;
        check("reset_out", {txd, fifo_rd_en, busy}, 3'b100);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        step();
        check("idle_out", {txd, fifo_rd_en, busy}, 3'b100);

        stim_q = '{8'hA5};
        run("a5_div3", 3, 3, -1, 1'b0, -1, 1'b0);

        stim_q = '{8'h00, 8'hFF};
        run("b2b_div0", 0, 0, -1, 1'b1, -1, 1'b0);

        stim_q = '{8'h5A, 8'h11, 8'h22};
        run("txen_off", 3, 3, -1, 1'b0, 7, 1'b0);

        stim_q = '{8'hC3, 8'h3C};
        run("div_chg", 3, 7, 10, 1'b0, -1, 1'b0);

`ifdef UART_TX_PARITY_EN
        stim_q = '{8'h07};
        run("par_even", 1, 1, -1, 1'b0, -1, 1'b0);
        run("par_odd", 1, 1, -1, 1'b0, -1, 1'b1);
`endif

        for (int t = 0; t < 5; t++) begin
            stim_q.delete();
            for (int k = 0; k <= int'($urandom_range(2, 0)); k++) begin
                stim_q.push_back(8'($urandom));
            end
            run($sformatf("rnd%0d", t), int'($urandom_range(4, 0)),
                int'($urandom_range(4, 0)), int'($urandom_range(30, 0)),
                1'($urandom), -1, 1'($urandom));
        end

        stim_q     = '{8'h3C};
        fifo_q     = stim_q;
        fifo_empty = 1'b0;
        div        = 16'd3;
        nstop      = 1'b0;
        txen       = 1'b1;
        pops       = 0;
        prev_rd    = 1'b0;
        repeat (10) step();
        check("pre_rst_busy", {txd, fifo_rd_en, busy}, {txd, 2'b01});
        #2 reset = 1'b1;
        #1;
        check("rst_async", {txd, fifo_rd_en, busy}, 3'b100);
        #3 reset = 1'b0;
        txen       = 1'b0;
        fifo_empty = 1'b1;
        prev_rd    = 1'b0;
        step();
        step();
        check("rst_idle", {txd, fifo_rd_en, busy}, 3'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
